trace_sink: RTL and testbench

TRACE_SINK -- requirements
Module: trace_sink

---
 rtl/trace_sink_if.sv | 43 ++++
 rtl/trace_sink.sv | 154 +++++++++++++++
 tb/tb_trace_sink.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/trace_sink_if.sv
// trace_sink_if: groups the trace record stream and the Avalon-MM write
// master bus used by trace_sink.
//   trace_in_data   [127:0]  record from the trace source
//   trace_in_valid           source has a record
//   trace_in_ready           sink accepts the record this cycle
//   avm_address     [31:0]   byte address of the current word write
//   avm_write                write strobe
//   avm_writedata   [31:0]   word being written
//   avm_byteenable  [3:0]    byte lanes (always all four)
//   avm_waitrequest          slave stalls the current write
// Modport master is the sink side (trace_sink); slave is the environment side.
interface trace_sink_if;
    logic [127:0] trace_in_data;
    logic         trace_in_valid;
    logic         trace_in_ready;
    logic [31:0]  avm_address;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [3:0]   avm_byteenable;
    logic         avm_waitrequest;

    modport master (
        input  trace_in_data,
        input  trace_in_valid,
        input  avm_waitrequest,
        output trace_in_ready,
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable
    );

    modport slave (
        output trace_in_data,
        output trace_in_valid,
        output avm_waitrequest,
        input  trace_in_ready,
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable
    );
endinterface

// File: rtl/trace_sink.sv
// trace_sink: accepts 128-bit trace records and writes each one into a ring
// buffer in memory as four 32-bit Avalon-MM word writes (word 0 first).
// Ports:
//   clk_clk    single clock
//   reset      asynchronous, active-high reset
//   enable     capture permitted (a record already being written always completes)
//   clear      synchronous pulse, honoured in IDLE only: restarts the ring
//   bus        trace_sink_if.master: trace record stream + Avalon-MM master
//   rec_count  number of records fully written (wraps modulo 2^32)
//   wrapped    sticky: ring wrapped at least once
//   stopped    sticky: ring filled and capture halted
// Parameters: BUF_BASE (16-byte aligned ring base), BUF_RECORDS (ring size).
// Build option: define TRACE_SINK_WRAP_EN to make the ring wrap around and
// keep capturing; without it the sink stops after the last slot is written.
module trace_sink #(
    parameter logic [31:0] BUF_BASE    = 32'h0100_0000,
    parameter int unsigned BUF_RECORDS = 1024
) (
    input  logic                clk_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    trace_sink_if.master        bus,
    output logic [31:0]         rec_count,
    output logic                wrapped,
    output logic                stopped
);

    localparam int unsigned IDX_W = (BUF_RECORDS > 1) ? $clog2(BUF_RECORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_RECORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       beat, beat_nxt;
    logic [IDX_W-1:0] rec_idx, rec_idx_nxt;
    logic [31:0]      rec_count_nxt;
    logic             stopped_nxt;
    logic [127:0]     rec_data_p0;
    logic             hs;

`ifdef TRACE_SINK_WRAP_EN
    logic             wrapped_q, wrapped_nxt;
    assign wrapped = wrapped_q;
`else
    assign wrapped = 1'b0;
`endif

    function automatic logic [31:0] select_word(input logic [127:0] rec,
                                                input logic [1:0]   idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = rec[31:0];
            2'd1:    w = rec[63:32];
            2'd2:    w = rec[95:64];
            default: w = rec[127:96];
        endcase
        return w;
    endfunction

    // Ready is gated by reset so the source sees no acceptance while the
    // block is held in reset, even with enable high.
    assign bus.trace_in_ready = !reset && (state == IDLE) && enable && !stopped && !clear;
    assign hs                 = bus.trace_in_valid && bus.trace_in_ready;

    // Address and data are pure functions of registered state, so they hold
    // still for as long as waitrequest stalls the beat. In IDLE beat is 0,
    // which also makes the reset address equal to BUF_BASE.
    assign bus.avm_write      = (state == WRITE);
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_address    = BUF_BASE + (32'(rec_idx) << 4) + (32'(beat) << 2);
    assign bus.avm_writedata  = (state == WRITE) ? select_word(rec_data_p0, beat) : 32'd0;

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        rec_idx_nxt   = rec_idx;
        rec_count_nxt = rec_count;
        stopped_nxt   = stopped;
`ifdef TRACE_SINK_WRAP_EN
        wrapped_nxt   = wrapped_q;
`endif
        case (state)
            IDLE: begin
                if (clear) begin
                    rec_idx_nxt   = '0;
                    rec_count_nxt = 32'd0;
                    stopped_nxt   = 1'b0;
`ifdef TRACE_SINK_WRAP_EN
                    wrapped_nxt   = 1'b0;
`endif
                end else if (hs) begin
                    state_nxt = WRITE;
                    beat_nxt  = 2'd0;
                end
            end
            WRITE: begin
                if (!bus.avm_waitrequest) begin
                    if (beat == 2'd3) begin
                        state_nxt     = IDLE;
                        beat_nxt      = 2'd0;
                        rec_count_nxt = rec_count + 32'd1;
                        if (rec_idx == LAST_IDX) begin
`ifdef TRACE_SINK_WRAP_EN
                            rec_idx_nxt = '0;
                            wrapped_nxt = 1'b1;
`else
                            stopped_nxt = 1'b1;
`endif
                        end else begin
                            rec_idx_nxt = rec_idx + IDX_W'(1);
                        end
                    end else begin
                        beat_nxt = beat + 2'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= 2'd0;
            rec_idx   <= '0;
            rec_count <= 32'd0;
            stopped   <= 1'b0;
`ifdef TRACE_SINK_WRAP_EN
            wrapped_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            rec_idx   <= rec_idx_nxt;
            rec_count <= rec_count_nxt;
            stopped   <= stopped_nxt;
`ifdef TRACE_SINK_WRAP_EN
            wrapped_q <= wrapped_nxt;
`endif
        end
    end

    // Record capture stage: data is only consumed in WRITE, so it needs no reset.
    always_ff @(posedge clk_clk) begin
        if (hs) begin
            rec_data_p0 <= bus.trace_in_data;
        end
    end

endmodule

// File: tb/tb_trace_sink.sv
module tb_trace_sink;

    localparam logic [31:0] B = 32'h0100_0000;
`ifdef TRACE_SINK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b1;
    logic        clear   = 1'b0;
    logic [31:0] rec_count;
    logic        wrapped;
    logic        stopped;

    trace_sink_if bus();

    trace_sink #(
        .BUF_BASE    (B),
        .BUF_RECORDS (2)
    ) dut (
        .clk_clk   (clk_clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .bus       (bus),
        .rec_count (rec_count),
        .wrapped   (wrapped),
        .stopped   (stopped)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic         en, clr, vld;
        logic [127:0] data;
        logic         wreq;
        logic         rdy, wr;
        logic [31:0]  addr, wdata, cnt;
        logic         wrp, stp;
    } vec_t;

    vec_t vt[16];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] D1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] D2 = 128'h40404040_30303030_20202020_10101010;

    function automatic vec_t mk(input logic en, clr, vld, input logic [127:0] data,
                                input logic wreq, rdy, wr, input logic [31:0] addr,
                                input logic [31:0] wdata, cnt, input logic wrp, stp);
        vec_t v;
        v.en = en; v.clr = clr; v.vld = vld; v.data = data; v.wreq = wreq;
        v.rdy = rdy; v.wr = wr; v.addr = addr; v.wdata = wdata; v.cnt = cnt;
        v.wrp = wrp; v.stp = stp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic rdy, wr,
                            input logic [31:0] addr, wdata, cnt, input logic wrp, stp);
        chk({tag, ".ready"},  32'(bus.trace_in_ready), 32'(rdy));
        chk({tag, ".write"},  32'(bus.avm_write),      32'(wr));
        chk({tag, ".addr"},   bus.avm_address,         addr);
        chk({tag, ".wdata"},  bus.avm_writedata,       wdata);
        chk({tag, ".be"},     32'(bus.avm_byteenable), 32'hF);
        chk({tag, ".count"},  rec_count,               cnt);
        chk({tag, ".wrapped"},32'(wrapped),            32'(wrp));
        chk({tag, ".stopped"},32'(stopped),            32'(stp));
    endtask

    initial begin
        int nwr;
        bus.trace_in_valid  = 1'b1;
        bus.trace_in_data   = D1;
        bus.avm_waitrequest = 1'b0;

        // Cycle table: inputs held for one cycle, outputs expected during it.
        vt[0]  = mk(1,0,1,D1,0,  1,0,B,      32'h0,        0,0,0);
        vt[1]  = mk(1,0,0,0, 0,  0,1,B,      32'h1,        0,0,0);
        vt[2]  = mk(1,0,0,0, 0,  0,1,B+4,    32'h2,        0,0,0);
        vt[3]  = mk(1,1,0,0, 1,  0,1,B+8,    32'h3,        0,0,0);
        vt[4]  = mk(1,0,0,0, 1,  0,1,B+8,    32'h3,        0,0,0);
        vt[5]  = mk(1,0,0,0, 1,  0,1,B+8,    32'h3,        0,0,0);
        vt[6]  = mk(1,0,0,0, 0,  0,1,B+8,    32'h3,        0,0,0);
        vt[7]  = mk(1,0,0,0, 0,  0,1,B+12,   32'h4,        0,0,0);
        vt[8]  = mk(1,0,1,D2,0,  1,0,B+16,   32'h0,        1,0,0);
        vt[9]  = mk(1,0,0,0, 0,  0,1,B+16,   32'h10101010, 1,0,0);
        vt[10] = mk(1,0,0,0, 0,  0,1,B+20,   32'h20202020, 1,0,0);
        vt[11] = mk(1,0,0,0, 0,  0,1,B+24,   32'h30303030, 1,0,0);
        vt[12] = mk(1,0,0,0, 0,  0,1,B+28,   32'h40404040, 1,0,0);
        vt[13] = mk(1,0,!WRAP,D1,0, WRAP,0, WRAP ? B : B+16, 32'h0, 2, WRAP, !WRAP);
        vt[14] = mk(1,1,1,D1,0,  0,0, WRAP ? B : B+16, 32'h0, 2, WRAP, !WRAP);
        vt[15] = mk(1,0,0,0, 0,  1,0,B,      32'h0,        0,0,0);

        // Reset state, with enable and valid high.
        @(negedge clk_clk);
        @(negedge clk_clk);
        #1;
        chk_outs("reset", 0,0,B,32'h0,0,0,0);

        @(negedge clk_clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable              = vt[i].en;
            clear               = vt[i].clr;
            bus.trace_in_valid  = vt[i].vld;
            bus.trace_in_data   = vt[i].data;
            bus.avm_waitrequest = vt[i].wreq;
            #1;
            chk_outs($sformatf("row%0d", i), vt[i].rdy, vt[i].wr, vt[i].addr,
                     vt[i].wdata, vt[i].cnt, vt[i].wrp, vt[i].stp);
            @(negedge clk_clk);
        end

        // Enable dropped during beat 0: record completes, nothing new accepted.
        enable = 1'b1; clear = 1'b0; bus.avm_waitrequest = 1'b0;
        bus.trace_in_valid = 1'b1; bus.trace_in_data = D2;
        #1;
        chk("en_drop.ready_before", 32'(bus.trace_in_ready), 32'h1);
        @(negedge clk_clk);
        enable = 1'b0;
        nwr = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (bus.avm_write && !bus.avm_waitrequest) nwr++;
            chk("en_drop.ready_off", 32'(bus.trace_in_ready), 32'h0);
            @(negedge clk_clk);
        end
        chk("en_drop.writes", 32'(nwr), 32'd4);
        chk("en_drop.count", rec_count, 32'd1);
        chk("en_drop.stopped", 32'(stopped), 32'h0);
        bus.trace_in_valid = 1'b0;
        enable = 1'b1;
        #1;
        chk("en_drop.ready_back", 32'(bus.trace_in_ready), 32'h1);

        // Reset during beat 1 of a record in slot 1.
        @(negedge clk_clk);
        bus.trace_in_valid = 1'b1; bus.trace_in_data = D2;
        @(negedge clk_clk);
        bus.trace_in_valid = 1'b0;
        @(negedge clk_clk);
        #1;
        chk("rst_mid.addr_b1", bus.avm_address, B+20);
        chk("rst_mid.write_b1", 32'(bus.avm_write), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("rst_mid", 0,0,B,32'h0,0,0,0);
        @(negedge clk_clk);
        reset = 1'b0;
        bus.trace_in_valid = 1'b1; bus.trace_in_data = D1;
        #1;
        chk("post_rst.ready", 32'(bus.trace_in_ready), 32'h1);
        @(negedge clk_clk);
        bus.trace_in_valid = 1'b0;
        #1;
        chk("post_rst.write", 32'(bus.avm_write), 32'h1);
        chk("post_rst.addr", bus.avm_address, B);
        chk("post_rst.wdata", bus.avm_writedata, 32'h1);
        @(negedge clk_clk);
        @(negedge clk_clk);
        #1;
        chk("post_rst.addr_b2", bus.avm_address, B+8);
        @(negedge clk_clk);
        @(negedge clk_clk);
        #1;
        chk("post_rst.count", rec_count, 32'd1);
        chk("post_rst.idle", 32'(bus.avm_write), 32'h0);
        chk("post_rst.next_addr", bus.avm_address, B+16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
